// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequences PC, IF/ID and ID/EX stall/flush commands from jump,
// load-use, multi-cycle EX and debug-halt events.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        ex_busy_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic        halt_req_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        halt_ack_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {RUN, FLUSH, BUSY, HALT} state_t;

  // Flush cycles remaining after the jump cycle and the first FLUSH cycle.
  localparam logic [2:0] FCNT_INIT = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);

  state_t      state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        load_use;
  logic        run_eval;

  // EX load whose destination is read by the instruction in ID.
  assign load_use = ex_is_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((id_rs1_ren_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_ren_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // State, flush countdown and event counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (stall_pc_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (jump_en_o)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  // Next state and Mealy control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    run_eval      = 1'b0;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'd0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    stall_id_ex_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    halt_ack_o    = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      FLUSH: begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (fcnt_q == 3'd0) state_d = RUN;
        else                fcnt_d  = fcnt_q - 3'd1;
      end
      BUSY: begin
        if (ex_busy_i) begin
          stall_pc_o    = 1'b1;
          stall_if_id_o = 1'b1;
          stall_id_ex_o = 1'b1;
        end else begin
          // EX result completes this cycle, so evaluate as a normal RUN cycle.
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      HALT: begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        halt_ack_o    = 1'b1;
        if (!halt_req_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (run_eval) begin
      if (jump_en_i) begin
        jump_en_o     = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_INIT;
        end else begin
          state_d = RUN;
        end
      end else if (ex_busy_i) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        stall_id_ex_o = 1'b1;
        state_d       = BUSY;
      end else if (load_use) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (halt_req_i) begin
        state_d = HALT;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random stimulus checked against a cycle-level
// behavioural model of the pipeline controller.
module tb_pipe_ctrl;

  localparam int unsigned FC = 3;

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        busy;
    logic        is_load;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        ren1;
    logic        ren2;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic jump_en;
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic halt_ack;
  } ctl_t;

  logic        clk, rst;
  logic        jump_en_i, ex_busy_i, ex_is_load_i, id_rs1_ren_i, id_rs2_ren_i, halt_req_i;
  logic [31:0] jump_addr_i;
  logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
  logic        jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o;
  logic        flush_if_id_o, flush_id_ex_o, halt_ack_o;
  logic [31:0] jump_addr_o, stall_cnt_o, flush_cnt_o;
  ctl_t        dut_ctl;

  int checks = 0;
  int errors = 0;

  // Model state: cycles of flushing still owed, whether a busy op is being
  // waited on, whether the core is halted, and the two event counts.
  int          m_flush_left;
  bit          m_busy;
  bit          m_halt;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;

  pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_busy_i(ex_busy_i), .ex_is_load_i(ex_is_load_i),
    .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_ren_i(id_rs1_ren_i), .id_rs2_ren_i(id_rs2_ren_i),
    .halt_req_i(halt_req_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o),
    .stall_id_ex_o(stall_id_ex_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .halt_ack_o(halt_ack_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  assign dut_ctl = '{jump_en_o, stall_pc_o, stall_if_id_o, stall_id_ex_o,
                     flush_if_id_o, flush_id_ex_o, halt_ack_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flush_left = 0;
    m_busy       = 1'b0;
    m_halt       = 1'b0;
    m_scnt       = 32'd0;
    m_fcnt       = 32'd0;
  endtask

  // Expected outputs of one cycle, then advance the model to the next cycle.
  task automatic model_cycle(input in_t s, output ctl_t e, output logic [31:0] ea);
    bit lu;
    lu = s.is_load && (s.rd != 0) &&
         ((s.ren1 && s.rs1 == s.rd) || (s.ren2 && s.rs2 == s.rd));
    e  = '0;
    ea = 32'd0;
    if (m_flush_left > 0) begin
      e.flush_if_id = 1'b1;
      e.flush_id_ex = 1'b1;
      m_flush_left--;
    end else if (m_halt) begin
      e.stall_pc    = 1'b1;
      e.stall_if_id = 1'b1;
      e.flush_id_ex = 1'b1;
      e.halt_ack    = 1'b1;
      if (!s.halt) m_halt = 1'b0;
    end else if (m_busy && s.busy) begin
      e.stall_pc    = 1'b1;
      e.stall_if_id = 1'b1;
      e.stall_id_ex = 1'b1;
    end else begin
      m_busy = 1'b0;
      if (s.jump) begin
        e.jump_en     = 1'b1;
        ea            = s.addr;
        e.flush_if_id = 1'b1;
        e.flush_id_ex = 1'b1;
        m_fcnt++;
        m_flush_left  = int'(FC) - 1;
      end else if (s.busy) begin
        e.stall_pc    = 1'b1;
        e.stall_if_id = 1'b1;
        e.stall_id_ex = 1'b1;
        m_busy        = 1'b1;
      end else if (lu) begin
        e.stall_pc    = 1'b1;
        e.stall_if_id = 1'b1;
        e.flush_id_ex = 1'b1;
      end else if (s.halt) begin
        m_halt = 1'b1;
      end
    end
    if (e.stall_pc) m_scnt++;
  endtask

  task automatic apply(input in_t s);
    jump_en_i     = s.jump;
    jump_addr_i   = s.addr;
    ex_busy_i     = s.busy;
    ex_is_load_i  = s.is_load;
    ex_rd_addr_i  = s.rd;
    id_rs1_addr_i = s.rs1;
    id_rs2_addr_i = s.rs2;
    id_rs1_ren_i  = s.ren1;
    id_rs2_ren_i  = s.ren2;
    halt_req_i    = s.halt;
  endtask

  // One clock cycle: drive after the falling edge, check, cross the rising edge.
  task automatic step(input string tag, input in_t s);
    ctl_t        e;
    logic [31:0] ea;
    apply(s);
    #1;
    check({tag, ".stall_cnt"}, stall_cnt_o, m_scnt);
    check({tag, ".flush_cnt"}, flush_cnt_o, m_fcnt);
    model_cycle(s, e, ea);
    check({tag, ".ctl"}, 32'(dut_ctl), 32'(e));
    check({tag, ".jump_addr"}, jump_addr_o, ea);
    @(posedge clk);
    @(negedge clk);
  endtask

  in_t idle, s;

  initial begin
    idle = '{default: '0};
    rst  = 1'b0;
    apply(idle);
    model_reset();

    // Reset: all outputs and counters zero.
    #12;
    check("reset.ctl", 32'(dut_ctl), 32'd0);
    check("reset.addr", jump_addr_o, 32'd0);
    check("reset.stall_cnt", stall_cnt_o, 32'd0);
    check("reset.flush_cnt", flush_cnt_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("idle", idle);

    // Jump with three flush cycles.
    s = idle; s.jump = 1'b1; s.addr = 32'h0000_0100;
    step("jump", s);
    s = idle; s.jump = 1'b1; s.busy = 1'b1; s.halt = 1'b1;   // ignored in FLUSH
    step("jump.f1", s);
    step("jump.f2", idle);
    step("jump.after", idle);

    // Load-use on rs2, then the same with rd = x0.
    s = idle; s.is_load = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.ren2 = 1'b1;
    step("lu", s);
    step("lu.after", idle);
    s.rd = 5'd0; s.rs2 = 5'd0;
    step("lu.x0", s);
    s = idle; s.is_load = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.ren1 = 1'b0;
    step("lu.noren", s);

    // Busy for four cycles, jump in the release cycle.
    s = idle; s.busy = 1'b1;
    step("busy0", s);
    s.jump = 1'b1; s.addr = 32'hDEAD_BEEF;                  // ignored while busy
    step("busy1", s);
    step("busy2", s);
    s.jump = 1'b0;
    step("busy3", s);
    s = idle; s.jump = 1'b1; s.addr = 32'h0000_2000;
    step("busy.rel_jump", s);
    step("busy.f1", idle);
    step("busy.f2", idle);

    // Halt raised with busy: deferred until busy ends.
    s = idle; s.busy = 1'b1; s.halt = 1'b1;
    step("hb0", s);
    step("hb1", s);
    s.busy = 1'b0;
    step("hb.rel", s);
    step("halt0", s);
    s.jump = 1'b1;                                          // ignored in HALT
    step("halt1", s);
    step("halt.drop", idle);
    step("halt.after", idle);

    // Async reset during HALT drops halt_ack at once.
    s = idle; s.halt = 1'b1;
    step("h2.req", s);
    step("h2.halted", s);
    apply(s);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst.halt_ack", 32'(halt_ack_o), 32'd0);
    check("async_rst.ctl", 32'(dut_ctl), 32'd0);
    check("async_rst.stall_cnt", stall_cnt_o, 32'd0);
    model_reset();
    @(negedge clk);
    apply(idle);
    rst = 1'b1;
    step("post_rst", idle);

    // Stall counter wraps to zero.
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFF;
    s = idle; s.is_load = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.ren1 = 1'b1;
    step("wrap.stall", s);
    step("wrap.after", idle);

    // Random traffic over a small register space to hit hazards often.
    for (int i = 0; i < 2000; i++) begin
      s.jump    = ($urandom_range(7) == 0);
      s.addr    = $urandom;
      s.busy    = ($urandom_range(3) == 0);
      s.is_load = $urandom_range(1) == 1;
      s.rd      = 5'($urandom_range(3));
      s.rs1     = 5'($urandom_range(3));
      s.rs2     = 5'($urandom_range(3));
      s.ren1    = $urandom_range(1) == 1;
      s.ren2    = $urandom_range(1) == 1;
      s.halt    = ($urandom_range(5) == 0);
      step("rand", s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-signal control plane around the IF/ID and ID/EX pipeline registers and the PC. It resolves jump redirects, load-use hazards, multi-cycle EX operations and debug halt requests into per-stage stall (keep value) and flush (load NOP/zero) commands. It sits beside the decode stage, takes hazard inputs from ID and EX, and drives the PC, `if_id` and `id_ex` register controls.

## Interface
- `FLUSH_CYCLES`, 1: total cycles IF/ID and ID/EX are flushed per taken jump; legal range is 1..7.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `jump_en_i` input 1: EX stage taken branch or jump.
- `jump_addr_i` input 32: redirect target.
- `ex_busy_i` input 1: EX stage multi-cycle operation in progress; EX result is not ready.
- `ex_is_load_i` input 1: the instruction currently in EX is a load.
- `ex_rd_addr_i` input 5: destination register of the EX instruction.
- `id_rs1_addr_i`, `id_rs2_addr_i` input 5 each: ID source registers.
- `id_rs1_ren_i`, `id_rs2_ren_i` input 1 each: ID source-read enables.
- `halt_req_i` input 1: debug halt request, level-sensitive.
- `jump_en_o` output 1: PC redirect strobe.
- `jump_addr_o` output 32: PC redirect target.
- `stall_pc_o`, `stall_if_id_o`, `stall_id_ex_o` output 1 each: hold the current value of the PC, IF/ID and ID/EX respectively.
- `flush_if_id_o`, `flush_id_ex_o` output 1 each: load NOP into IF/ID and ID/EX respectively.
- `halt_ack_o` output 1: core halted.
- `stall_cnt_o` output 32: cycles with `stall_pc_o`=1.
- `flush_cnt_o` output 32: count of accepted jumps.

## Operation
- FSM states: RUN, FLUSH, BUSY, HALT. The state register is 2 bits. A flush counter `fcnt` is 3 bits.
- Outputs are Mealy: a combinational function of the state and the inputs. The state, `fcnt` and both counters are registered.
- `load_use` = `ex_is_load_i` & (`ex_rd_addr_i`≠0) & ((`id_rs1_ren_i` & `id_rs1_addr_i`==`ex_rd_addr_i`) | (`id_rs2_ren_i` & `id_rs2_addr_i`==`ex_rd_addr_i`)).
- Priority in RUN, highest first: jump, busy, load_use, halt.
  - **Jump:** `jump_en_o`=1, `jump_addr_o`=`jump_addr_i`, and both flush outputs are 1. This cancels any load_use or busy stall in the same cycle. `flush_cnt_o` increments.
    - If `FLUSH_CYCLES`>1: go to FLUSH with `fcnt`=`FLUSH_CYCLES`-2.
    - Otherwise stay in RUN.
  - **Busy:** all three stall outputs are 1 and no flush; go to BUSY.
  - **load_use:** `stall_pc_o`=`stall_if_id_o`=1 and `flush_id_ex_o`=1 (one bubble). Stay in RUN; the hazard clears naturally next cycle.
  - **Halt:** outputs are the same as in an idle RUN cycle; go to HALT.
- FLUSH state:
  - Both flush outputs are 1, all stall outputs are 0, and `jump_en_o`=0.
  - `jump_en_i`, `ex_busy_i` and `halt_req_i` are ignored.
  - When `fcnt`==0 go to RUN; otherwise decrement `fcnt`.
- BUSY state:
  - All three stall outputs are 1 while `ex_busy_i`=1.
  - When `ex_busy_i`=0: treat the cycle as RUN (full priority evaluation, outputs and transitions), since the EX result completes this cycle.
- HALT state:
  - `stall_pc_o`=`stall_if_id_o`=1, `flush_id_ex_o`=1, `halt_ack_o`=1.
  - When `halt_req_i`=0, go to RUN next cycle.
  - `jump_en_i` is ignored, because EX holds a NOP.
- `jump_addr_o`=`jump_addr_i` whenever `jump_en_o`=1, and 0 otherwise.
- Stall and flush on the same register are never asserted together.
- Both counters are free-running and wrap from 0xFFFFFFFF to 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - State=RUN, `fcnt`=0, both counters=0, `halt_ack_o`=0.
  - With all inputs at 0, every output is 0.
- Reset released mid-FLUSH, mid-BUSY or mid-HALT restarts in RUN with no residual flush or stall.
- Jump at cycle N: the redirect and both flushes are active in cycle N. Flushes continue through cycle N+`FLUSH_CYCLES`-1, and RUN evaluation resumes at N+`FLUSH_CYCLES`.
- Load-use at cycle N: one bubble. The PC and IF/ID advance again at N+1.
- Halt request at cycle N in an idle RUN: `halt_ack_o`=1 from N+1. After release at cycle M, `halt_ack_o`=0 from M+1.
- `halt_req_i` coinciding with a jump or busy: the halt is deferred until the first idle RUN cycle.

## Test plan
- **Reset:** reset asserted then released, all inputs 0 → all outputs 0, `stall_cnt_o`=`flush_cnt_o`=0.
- **Jump with `FLUSH_CYCLES`=3:** `jump_en_i`=1, `jump_addr_i`=0x0000_0100 for one cycle at N → `jump_en_o`=1 with addr 0x100 at N; both flushes high at N, N+1, N+2 and low at N+3; `flush_cnt_o`=1.
- **Load-use:** `ex_is_load_i`=1, `ex_rd_addr_i`=5, `id_rs2_addr_i`=5, `id_rs2_ren_i`=1 → one cycle of `stall_pc_o`/`stall_if_id_o`/`flush_id_ex_o`; `stall_cnt_o`=1.
  - Repeat with `ex_rd_addr_i`=0 → no stall.
- **Busy:** `ex_busy_i` high for 4 cycles → the three stall outputs are high for exactly those 4 cycles.
  - Jump asserted in the release cycle → flush, no stall.
- **Halt:** `halt_req_i` raised together with `ex_busy_i` → `halt_ack_o` rises one cycle after busy ends.
  - Drop `halt_req_i` → `halt_ack_o`=0 the next cycle.
  - Async reset pulse asserted during HALT → `halt_ack_o` drops immediately.
- **Counter wrap:** force `stall_cnt_o` to 0xFFFFFFFF, then one stall cycle → reads 0.
